// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of a producer index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - rotate-priority encoder starting just after last_owner
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    int idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_owner) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          grant_valid,
    output logic [id_width(NUM_REQ)-1:0]  grant_id,
    output logic                          err_overflow,
    output logic                          err_noack
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_e       state;
    logic [ID_W-1:0]  last_owner;
    logic [CNT_W-1:0] beat_cnt;
    logic             wr_en_q;
    logic             pick_any;
    logic [ID_W-1:0]  pick_id;
    logic             beat;
    logic             burst_end;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req        (req_valid),
        .last_owner (last_owner),
        .any        (pick_any),
        .winner     (pick_id)
    );

    assign grant_valid = (state == BURST);

    // Ready is withheld while full so the owner stalls instead of dropping a word.
    always_comb begin
        req_ready = '0;
        if (grant_valid && !fifo_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign beat         = grant_valid & req_valid[grant_id] & ~fifo_full;
    assign fifo_wr_en   = beat;
    assign fifo_data_in = grant_valid ? req_data[grant_id*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    assign burst_end    = (beat && (beat_cnt == CNT_W'(MAX_BURST - 1)))
                        || !req_valid[grant_id] || fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= ID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (burst_end) begin
                        last_owner <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The FIFO acknowledges one cycle after the write it accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            err_noack    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_en_q <= fifo_wr_en;
            if (wr_en_q && !fifo_wr_ack) begin
                err_noack <= 1'b1;
            end
            if (fifo_overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int FW = 16;
    localparam int NR = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR*FW-1:0] req_data = '0;
    logic [NR-1:0] req_ready;
    logic          fifo_wr_en;
    logic [FW-1:0] fifo_data_in;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_ack = 1'b0;
    logic          fifo_overflow = 1'b0;
    logic          grant_valid;
    logic [1:0]    grant_id;
    logic          err_overflow;
    logic          err_noack;

    fifo_wr_arbiter #(
        .FIFO_WIDTH (FW),
        .FIFO_DEPTH (8),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_wr_ack   (fifo_wr_ack),
        .fifo_overflow (fifo_overflow),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .err_overflow  (err_overflow),
        .err_noack     (err_noack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: owner is -1 while no burst is running.
    int m_owner, m_last, m_beats;
    bit m_prev_wr, m_noack, m_ovf;
    int left[NR];
    int sent[NR];
    int dut_starts[$];
    bit gv_prev;
    int wr_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] word_of(input int i);
        logic [31:0] id;
        logic [31:0] n;
        id = i;
        n  = sent[i];
        return {id[3:0], n[11:0]};
    endfunction

    task automatic step(input logic [NR-1:0] en, input logic full, input logic drop_ack, input logic ovf);
        logic [NR-1:0] v;
        logic beat;
        int o;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            v[i] = en[i] && (left[i] > 0);
            req_data[i*FW +: FW] = word_of(i);
        end
        req_valid     = v;
        fifo_full     = full;
        fifo_wr_ack   = m_prev_wr && !drop_ack;
        fifo_overflow = ovf;
        #1;
        o    = m_owner;
        beat = (o >= 0) && v[o] && !full;
        check("grant_valid", grant_valid, (o >= 0));
        if (o >= 0) check("grant_id", grant_id, o);
        check("req_ready", req_ready, (o >= 0 && !full) ? (32'd1 << o) : 32'd0);
        check("wr_en", fifo_wr_en, beat);
        check("data_in", fifo_data_in, (o >= 0) ? word_of(o) : 16'h0);
        check("err_noack", err_noack, m_noack);
        check("err_overflow", err_overflow, m_ovf);
        if (grant_valid && !gv_prev) dut_starts.push_back(int'(grant_id));
        gv_prev = grant_valid;
        if (fifo_wr_en) wr_seen++;
        if (m_prev_wr && !fifo_wr_ack) m_noack = 1'b1;
        if (ovf) m_ovf = 1'b1;
        m_prev_wr = beat;
        if (o < 0) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (m_owner < 0 && v[c]) begin
                    m_owner = c;
                    m_beats = 0;
                end
            end
        end else begin
            if (beat) begin
                sent[o]++;
                left[o]--;
                m_beats++;
            end
            if ((beat && m_beats == MB) || !v[o] || full) begin
                m_last  = o;
                m_owner = -1;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_data", fifo_data_in, 0);
        check("rst_err_noack", err_noack, 0);
        check("rst_err_overflow", err_overflow, 0);
        req_valid = '0;
        fifo_full = 1'b0;
        fifo_wr_ack = 1'b0;
        fifo_overflow = 1'b0;
        m_owner = -1;
        m_last = NR - 1;
        m_beats = 0;
        m_prev_wr = 1'b0;
        m_noack = 1'b0;
        m_ovf = 1'b0;
        gv_prev = 1'b0;
        dut_starts.delete();
        wr_seen = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_all(input int n);
        for (int i = 0; i < NR; i++) left[i] = n;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) sent[i] = 0;

        // Single producer with three words.
        fill_all(0);
        do_reset();
        left[0] = 3;
        for (int n = 0; n < 6; n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t1_beats", wr_seen, 3);
        check("t1_first_owner", (dut_starts.size() > 0) ? dut_starts[0] : -1, 0);
        check("t1_back_idle", grant_valid, 0);

        // All producers saturating: strict rotation.
        do_reset();
        fill_all(100);
        for (int n = 0; n < 26; n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t2_nstarts", dut_starts.size() >= 5, 1);
        if (dut_starts.size() >= 5) begin
            check("t2_order0", dut_starts[0], 0);
            check("t2_order1", dut_starts[1], 1);
            check("t2_order2", dut_starts[2], 2);
            check("t2_order3", dut_starts[3], 3);
            check("t2_order4", dut_starts[4], 0);
        end

        // FIFO full two beats into producer 2's burst.
        do_reset();
        fill_all(100);
        for (int n = 0; n < 60 && !(m_owner == 2 && m_beats == 2); n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t3_reach", (m_owner == 2 && m_beats == 2), 1);
        step(4'hf, 1'b1, 1'b0, 1'b0);
        dut_starts.delete();
        for (int n = 0; n < 3; n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t3_next_owner", (dut_starts.size() > 0) ? dut_starts[0] : -1, 3);

        // Producer 1 runs dry after one beat.
        do_reset();
        fill_all(0);
        left[1] = 1;
        left[2] = 5;
        for (int n = 0; n < 6; n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t4_first", (dut_starts.size() > 0) ? dut_starts[0] : -1, 1);
        check("t4_second", (dut_starts.size() > 1) ? dut_starts[1] : -1, 2);
        check("t4_no_err", err_noack, 0);

        // Missing ack and overflow pulse are both sticky.
        do_reset();
        fill_all(100);
        for (int n = 0; n < 20 && !m_prev_wr; n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t5_reach", m_prev_wr, 1);
        step(4'hf, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t5_noack_sticky", err_noack, 1);
        step(4'hf, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3; n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t5_ovf_sticky", err_overflow, 1);

        // Reset in the middle of a burst.
        do_reset();
        fill_all(100);
        for (int n = 0; n < 20 && !(m_owner >= 0 && m_beats == 1); n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t6_reach", (m_owner >= 0 && m_beats == 1), 1);
        do_reset();
        for (int n = 0; n < 3; n++) step(4'hf, 1'b0, 1'b0, 1'b0);
        check("t6_first_owner", (dut_starts.size() > 0) ? dut_starts[0] : -1, 0);

        // Random producers and back-pressure.
        do_reset();
        fill_all(0);
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (left[i] == 0 && ($urandom % 4) == 0) left[i] = $urandom_range(1, 10);
            end
            step(NR'($urandom), ($urandom % 5) == 0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares a single FIFO write port among NUM_REQ producers. Each producer uses a valid/ready handshake; the arbiter grants one owner at a time for a bounded burst and drives the FIFO's `wr_en`/`data_in` from that owner. It sits directly in front of the FIFO and monitors `full`, `wr_ack` and `overflow` for protocol errors.

## Interface
- FIFO_WIDTH, 16, data word width (matches FIFO)
- FIFO_DEPTH, 8, FIFO depth (informational; sizes nothing here beyond checks)
- NUM_REQ, 4, number of producers (2..16)
- MAX_BURST, 4, max beats per grant (1..16)

- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  producer i has a word
- req_data  input  NUM_REQ*FIFO_WIDTH  producer i word at bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- req_ready  output  NUM_REQ  word of producer i accepted this cycle when valid&ready
- fifo_wr_en  output  1  to FIFO wr_en
- fifo_data_in  output  FIFO_WIDTH  to FIFO data_in
- fifo_full  input  1  from FIFO full
- fifo_wr_ack  input  1  from FIFO wr_ack
- fifo_overflow  input  1  from FIFO overflow
- grant_valid  output  1  a burst is in progress
- grant_id  output  $clog2(NUM_REQ)  current owner
- err_overflow  output  1  sticky: overflow seen
- err_noack  output  1  sticky: write not acknowledged

## Operation
- FSM states: IDLE, BURST.
- IDLE: if any req_valid, pick owner by round-robin starting at last_owner+1 (wrapping), latch grant_id, clear beat_cnt, go BURST. Else stay.
- BURST: req_ready[grant_id] = !fifo_full; all other req_ready = 0. Beat = req_valid[grant_id] & req_ready[grant_id]; beat_cnt increments per beat.
- fifo_wr_en = beat; fifo_data_in = req_data slice of grant_id (combinational mux; 0 when no grant).
- BURST exits to IDLE (last_owner <= grant_id) when: beat with beat_cnt == MAX_BURST-1, or req_valid[grant_id] low, or fifo_full high. Exit takes effect next cycle.
- The arbiter never asserts fifo_wr_en while fifo_full is high; a producer stalls when full rather than losing data.
- err_noack: set when fifo_wr_en was high last cycle and fifo_wr_ack is low this cycle.
- err_overflow: set when fifo_overflow is high. Both errors clear only on rst.
- beat_cnt width $clog2(MAX_BURST)+1; no wrap inside a burst.

## Timing
- Reset (async assert, sync deassert externally): state IDLE, last_owner = NUM_REQ-1 (producer 0 wins first), grant_id 0, grant_valid 0, beat_cnt 0, errors 0; req_ready and fifo_wr_en are 0.
- Grant latency: req_valid high in IDLE at edge N -> grant_valid high and first beat possible in cycle N+1.
- One idle cycle between consecutive bursts (re-arbitration bubble); peak throughput MAX_BURST/(MAX_BURST+1).
- fifo_wr_en is combinational from inputs within BURST; the FIFO captures on the same edge as the handshake.
- Owner drops valid mid-burst: no beat that cycle, return to IDLE; rotation continues past it.
- fifo_full during BURST: ready low that cycle, burst ends, owner is re-queued at lowest priority.
- rst mid-burst: all outputs drop immediately; no partial-state recovery.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, BURST), helper function for the id width.
- Sub-module rr_picker: combinational rotate-priority encoder (req vector, last_owner -> any, winner id).
- Top holds FSM, counters, data mux, error flags.

## Test plan
- Reset, then req_valid=4'b0001 with 3 words -> grant_id=0 one cycle later, 3 consecutive fifo_wr_en, return to IDLE.
- All 4 producers valid continuously, MAX_BURST=4 -> grant order 0,1,2,3,0, 4 beats each, 1 bubble cycle between bursts.
- fifo_full forced high during producer 2 burst after 2 beats -> req_ready[2]=0, no wr_en while full, next grant goes to 3.
- Producer 1 drops valid after 1 beat -> burst ends, no error, producer 2 granted next.
- Hold fifo_wr_ack low after a write -> err_noack=1 next cycle and stays until rst; pulse fifo_overflow -> err_overflow=1 sticky.
- Assert rst mid-burst -> fifo_wr_en, req_ready and grant_valid 0 immediately; after release, producer 0 is granted first.
